// File: rtl/tile_blitter.sv
// Tile-to-framebuffer copier: fetches packed 24-bit RGB pixels byte-by-byte from a
// latency-configurable ROM and emits one strobed write per opaque pixel on a shared tri-stated bus.
module tile_blitter #(
  parameter int          TILE_W      = 8,
  parameter int          TILE_H      = 8,
  parameter int          COORD_W     = 8,
  parameter int          ADDR_W      = 12,
  parameter int          ROM_LATENCY = 2,
  parameter bit          KEY_EN      = 1'b1,
  parameter logic [23:0] KEY_RGB     = 24'hFF00FF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_W-1:0]  tile_base,
  input  logic [COORD_W-1:0] x_pos,
  input  logic [COORD_W-1:0] y_pos,
  input  logic               flip_x,
  input  logic               flip_y,
  input  logic [7:0]         rom_data,
  output logic [ADDR_W-1:0]  rom_addr,
  output logic               vga_draw_enable_bus,
  output logic [COORD_W-1:0] vga_x_out_bus,
  output logic [COORD_W-1:0] vga_y_out_bus,
  output logic [23:0]        vga_RGB_out_bus,
  output logic               active,
  output logic               done
);

  localparam int COL_W = (TILE_W > 1) ? $clog2(TILE_W) : 1;
  localparam int ROW_W = (TILE_H > 1) ? $clog2(TILE_H) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(TILE_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(TILE_H - 1);
  localparam logic [2:0]       W_LAST   = 3'(ROM_LATENCY);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_FETCH = 3'd2;
  localparam logic [2:0] S_DRAW  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]         state;
  logic [COL_W-1:0]   col;
  logic [ROW_W-1:0]   row;
  logic [1:0]         ch;
  logic [2:0]         wcnt;
  logic               draw_q;
  logic               done_q;
  logic [COORD_W-1:0] x_q;
  logic [COORD_W-1:0] y_q;
  logic [23:0]        rgb_q;

  logic [ADDR_W-1:0]  src_addr;
  logic [COORD_W-1:0] x_org;
  logic [COORD_W-1:0] y_org;
  logic               fx;
  logic               fy;
  logic [7:0]         r_hold;
  logic [7:0]         g_hold;
  logic [7:0]         b_hold;

  logic [COORD_W-1:0] dx;
  logic [COORD_W-1:0] dy;
  logic [23:0]        pix;
  logic               opaque;

  always_comb begin
    dx     = fx ? (COORD_W'(TILE_W - 1) - COORD_W'(col)) : COORD_W'(col);
    dy     = fy ? (COORD_W'(TILE_H - 1) - COORD_W'(row)) : COORD_W'(row);
    pix    = {r_hold, g_hold, b_hold};
    opaque = !(KEY_EN && (pix == KEY_RGB));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      col      <= '0;
      row      <= '0;
      ch       <= 2'd0;
      wcnt     <= 3'd0;
      rom_addr <= '0;
      x_q      <= '0;
      y_q      <= '0;
      rgb_q    <= '0;
      draw_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      draw_q <= 1'b0;
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) state <= S_LOAD;
        end
        S_LOAD: begin
          col   <= '0;
          row   <= '0;
          ch    <= 2'd0;
          wcnt  <= 3'd0;
          state <= S_FETCH;
        end
        S_FETCH: begin
          // Address goes out at w=0; data is captured ROM_LATENCY edges later.
          if (wcnt == 3'd0) rom_addr <= src_addr;
          if (wcnt == W_LAST) begin
            wcnt <= 3'd0;
            if (ch == 2'd2) begin
              ch    <= 2'd0;
              state <= S_DRAW;
            end else begin
              ch <= ch + 2'd1;
            end
          end else begin
            wcnt <= wcnt + 3'd1;
          end
        end
        S_DRAW: begin
          x_q    <= x_org + dx;
          y_q    <= y_org + dy;
          rgb_q  <= pix;
          draw_q <= opaque;
          if (col == COL_LAST) begin
            col <= '0;
            if (row == ROW_LAST) begin
              row    <= '0;
              done_q <= 1'b1;
              state  <= S_DONE;
            end else begin
              row   <= row + ROW_W'(1);
              state <= S_FETCH;
            end
          end else begin
            col   <= col + COL_W'(1);
            state <= S_FETCH;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Tile parameters and channel holding registers are pure data and need no reset.
  always_ff @(posedge clk) begin
    if (state == S_LOAD) begin
      src_addr <= tile_base;
      x_org    <= x_pos;
      y_org    <= y_pos;
      fx       <= flip_x;
      fy       <= flip_y;
    end else if (state == S_FETCH) begin
      if (wcnt == 3'd0) src_addr <= src_addr + ADDR_W'(1);
      if (wcnt == W_LAST) begin
        case (ch)
          2'd0:    r_hold <= rom_data;
          2'd1:    g_hold <= rom_data;
          default: b_hold <= rom_data;
        endcase
      end
    end
  end

  assign active              = (state != S_IDLE);
  assign done                = done_q;
  assign vga_draw_enable_bus = active ? draw_q : 1'bz;
  assign vga_x_out_bus       = active ? x_q    : {COORD_W{1'bz}};
  assign vga_y_out_bus       = active ? y_q    : {COORD_W{1'bz}};
  assign vga_RGB_out_bus     = active ? rgb_q  : {24{1'bz}};

endmodule

// File: tb/tb_tile_blitter.sv
// Directed bench for tile_blitter: default-geometry instance plus a 16x4, latency-1 instance,
// each fed by a behavioural ROM whose byte n holds n mod 256.
module tb_tile_blitter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start0 = 1'b0;
  logic        start1 = 1'b0;
  logic [11:0] tile_base = '0;
  logic [7:0]  x_pos = '0;
  logic [7:0]  y_pos = '0;
  logic        flip_x = 1'b0;
  logic        flip_y = 1'b0;
  bit          key_mode = 1'b0;
  bit          sel = 1'b0;

  logic [7:0]  rom_data0, rom_data1;
  logic [11:0] rom_addr0, rom_addr1, addr_d0;
  logic        de0, de1, act0, act1, dn0, dn1;
  logic [7:0]  xo0, xo1, yo0, yo1;
  logic [23:0] rgb0, rgb1;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_byte(input logic [11:0] a, input bit km);
    if (km && a >= 12'd15 && a <= 12'd17) return (a == 12'd16) ? 8'h00 : 8'hFF;
    return a[7:0];
  endfunction

  always @(posedge clk) addr_d0 <= rom_addr0;
  assign rom_data0 = rom_byte(addr_d0, key_mode);
  assign rom_data1 = rom_byte(rom_addr1, key_mode);

  tile_blitter dut0 (
    .clk(clk), .reset(reset), .start(start0), .tile_base(tile_base),
    .x_pos(x_pos), .y_pos(y_pos), .flip_x(flip_x), .flip_y(flip_y),
    .rom_data(rom_data0), .rom_addr(rom_addr0), .vga_draw_enable_bus(de0),
    .vga_x_out_bus(xo0), .vga_y_out_bus(yo0), .vga_RGB_out_bus(rgb0),
    .active(act0), .done(dn0)
  );

  tile_blitter #(.TILE_W(16), .TILE_H(4), .ROM_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .tile_base(tile_base),
    .x_pos(x_pos), .y_pos(y_pos), .flip_x(flip_x), .flip_y(flip_y),
    .rom_data(rom_data1), .rom_addr(rom_addr1), .vga_draw_enable_bus(de1),
    .vga_x_out_bus(xo1), .vga_y_out_bus(yo1), .vga_RGB_out_bus(rgb1),
    .active(act1), .done(dn1)
  );

  // Write / address / timing log, fed from the instance chosen by sel.
  int  nw = 0, na = 0;
  int  wx[128], wy[128], wrgb[128], wc[128];
  int  alog[16];
  logic [11:0] last_addr = '0;
  int  load_cyc = -1, done_cyc = -1;
  bit  got_done = 1'b0, act_prev = 1'b0;
  logic m_de, m_act, m_dn;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    m_de  = sel ? de1  : de0;
    m_act = sel ? act1 : act0;
    m_dn  = sel ? dn1  : dn0;
    if (m_de === 1'b1) begin
      if (nw < 128) begin
        wx[nw]   = int'(sel ? xo1 : xo0);
        wy[nw]   = int'(sel ? yo1 : yo0);
        wrgb[nw] = int'(sel ? rgb1 : rgb0);
        wc[nw]   = cyc;
      end
      nw++;
    end
    if (m_act === 1'b1 && !act_prev) load_cyc = cyc;
    act_prev = (m_act === 1'b1);
    if (m_dn === 1'b1) begin
      done_cyc = cyc;
      got_done = 1'b1;
    end
    if (!sel && act0 === 1'b1 && rom_addr0 != last_addr) begin
      if (na < 16) alog[na] = int'(rom_addr0);
      na++;
      last_addr = rom_addr0;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_tile(input bit s, input int base, input int x, input int y,
                          input bit fxv, input bit fyv, input bit km, input bit mid);
    sel = s;
    key_mode = km;
    @(negedge clk);
    nw = 0; na = 0; got_done = 0; load_cyc = -1; done_cyc = -1;
    last_addr = rom_addr0;
    tile_base = 12'(base); x_pos = 8'(x); y_pos = 8'(y); flip_x = fxv; flip_y = fyv;
    if (s) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
    @(negedge clk);
    if (mid) begin
      repeat (3) @(negedge clk);
      tile_base = 12'h100; x_pos = 8'd0; y_pos = 8'd0;
      if (s) start1 = 1'b1; else start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0; start1 = 1'b0;
    end
    for (int i = 0; i < 3000 && !got_done; i++) @(negedge clk);
    if (!got_done) check("done_timeout", 0, 1);
    repeat (3) @(negedge clk);
  endtask

  typedef struct {
    bit sel; int base; int x; int y; bit fx; bit fy; bit km; bit mid;
    int nwr; int ncyc; int widx; int ex; int ey; int ergb;
  } vec_t;

  vec_t tbl[13];
  int found;

  initial begin
    tbl[0]  = '{0, 0,     10, 20, 0, 0, 0, 0, 64, 641,  0, 10, 20, 32'h000102};
    tbl[1]  = '{0, 0,     10, 20, 0, 0, 0, 0, 64, 641,  1, 11, 20, 32'h030405};
    tbl[2]  = '{0, 0,     10, 20, 0, 0, 0, 0, 64, 641,  8, 10, 21, 32'h18191A};
    tbl[3]  = '{0, 0,     10, 20, 0, 0, 0, 0, 64, 641, 63, 17, 27, 32'hBDBEBF};
    tbl[4]  = '{0, 0,     10, 20, 1, 1, 0, 0, 64, 641,  0, 17, 27, 32'h000102};
    tbl[5]  = '{0, 0,     10, 20, 1, 1, 0, 0, 64, 641, 63, 10, 20, 32'hBDBEBF};
    tbl[6]  = '{0, 0,     10, 20, 1, 0, 0, 0, 64, 641,  1, 16, 20, 32'h030405};
    tbl[7]  = '{0, 0,     10, 20, 0, 1, 0, 0, 64, 641,  8, 10, 26, 32'h18191A};
    tbl[8]  = '{0, 0,     10, 20, 0, 0, 1, 0, 63, 641,  5, 16, 20, 32'h121314};
    tbl[9]  = '{0, 'hFFD, 252, 0, 0, 0, 0, 1, 64, 641,  0, 252, 0, 32'hFDFEFF};
    tbl[10] = '{0, 'hFFD, 252, 0, 0, 0, 0, 1, 64, 641,  4,  0,  0, 32'h090A0B};
    tbl[11] = '{1, 0,     30, 40, 0, 0, 0, 0, 64, 449, 63, 45, 43, 32'hBDBEBF};
    tbl[12] = '{1, 0,     30, 40, 0, 0, 0, 0, 64, 449, 16, 30, 41, 32'h303132};

    // Reset state, both while held and after release.
    repeat (3) @(negedge clk);
    check("rst_active", int'(act0), 0);
    check("rst_rom_addr", int'(rom_addr0), 0);
    check("rst_strobe", int'(de0 === 1'b1), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_active", int'(act0), 0);
    check("idle_done", int'(dn0), 0);

    for (int k = 0; k < 13; k++) begin
      run_tile(tbl[k].sel, tbl[k].base, tbl[k].x, tbl[k].y,
               tbl[k].fx, tbl[k].fy, tbl[k].km, tbl[k].mid);
      check($sformatf("v%0d_writes", k), nw, tbl[k].nwr);
      check($sformatf("v%0d_cycles", k), done_cyc - load_cyc, tbl[k].ncyc);
      check($sformatf("v%0d_x", k), wx[tbl[k].widx], tbl[k].ex);
      check($sformatf("v%0d_y", k), wy[tbl[k].widx], tbl[k].ey);
      check($sformatf("v%0d_rgb", k), wrgb[tbl[k].widx], tbl[k].ergb);
    end

    // Keyed pixel 5 must leave no write at its screen position.
    run_tile(0, 0, 10, 20, 0, 0, 1, 0);
    found = 0;
    for (int i = 0; i < nw && i < 128; i++)
      if (wx[i] == 15 && wy[i] == 20) found++;
    check("key_no_write_15_20", found, 0);

    // Source address and screen x both wrap.
    run_tile(0, 'hFFD, 252, 0, 0, 0, 0, 0);
    check("wrap_addr0", alog[0], 'hFFD);
    check("wrap_addr1", alog[1], 'hFFE);
    check("wrap_addr2", alog[2], 'hFFF);
    check("wrap_addr3", alog[3], 'h000);
    check("wrap_x3", wx[3], 255);

    // Pixel period of the 16x4, latency-1 instance.
    run_tile(1, 0, 30, 40, 0, 0, 0, 0);
    check("sweep_period", wc[1] - wc[0], 7);
    check("sweep_period_row", wc[16] - wc[15], 7);

    // Reset during pixel 30, then a clean redraw.
    sel = 0; key_mode = 0;
    @(negedge clk);
    nw = 0; load_cyc = -1; got_done = 0;
    tile_base = 12'd0; x_pos = 8'd10; y_pos = 8'd20; flip_x = 0; flip_y = 0;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    for (int i = 0; i < 400 && !(load_cyc >= 0 && cyc >= load_cyc + 305); i++) @(negedge clk);
    check("mid_writes_before_reset", nw, 30);
    check("mid_addr_nonzero", int'(rom_addr0 != 12'd0), 1);
    reset = 1'b1;
    #1;
    check("mid_rst_active", int'(act0), 0);
    check("mid_rst_rom_addr", int'(rom_addr0), 0);
    check("mid_rst_strobe", int'(de0 === 1'b1), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("post_rst_no_write", nw, 30);
    check("post_rst_idle", int'(act0), 0);
    run_tile(0, 0, 10, 20, 0, 0, 0, 0);
    check("redraw_writes", nw, 64);
    check("redraw_x0", wx[0], 10);
    check("redraw_rgb0", wrgb[0], 'h000102);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
